test_monitor: RTL and testbench

- Synthesizable end-of-test monitor for riscv-tests runs on the SoC.
- Replaces hierarchical peeking at x3/x26/x27 with taps on each hart's register-file write port.
- Tracks per-hart test number, completion and result, enforces a global cycle timeout, and emits registered pass/fail/timeout status that the bench or a debug CSR can read.
- Generalised to NUM_HARTS harts, with configurable register indices and timeout.

---
 rtl/test_monitor_pkg.sv | 29 ++
 rtl/test_monitor_hart.sv | 73 +++++++
 rtl/test_monitor.sv | 131 +++++++++++++
 tb/tb_test_monitor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/test_monitor_pkg.sv
// Shared types and constants for the end-of-test monitor.
package test_monitor_pkg;

  // Per-hart tracker state.
  typedef enum logic [1:0] {
    H_RUN,
    H_PASSED,
    H_FAILED
  } hart_state_t;

  // Aggregate (whole-SoC) test state.
  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } agg_state_t;

  // Result register value that means "pass".
  localparam int unsigned RESULT_PASS = 1;
  // Done register value that marks end of test.
  localparam int unsigned DONE_MAGIC  = 1;

  // A hart is finished once it has left RUN.
  function automatic logic hart_finished(input hart_state_t s);
    return (s != H_RUN);
  endfunction

endpackage

// File: rtl/test_monitor_hart.sv
// One hart's register-file tap: shadows the test number and result
// registers and decides pass/fail when the done register is written.
module test_monitor_hart
  import test_monitor_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned TESTNUM_REG = 3,
  parameter int unsigned DONE_REG    = 26,
  parameter int unsigned RESULT_REG  = 27
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  output hart_state_t     o_state,
  output logic [XLEN-1:0] o_testnum
);

  hart_state_t     r_state;
  hart_state_t     w_state_nxt;
  logic [XLEN-1:0] r_testnum;
  logic [XLEN-1:0] r_result;
  logic            w_valid;
  logic            w_hit_testnum;
  logic            w_hit_result;
  logic            w_hit_done;

  // x0 writes never count.
  assign w_valid       = i_we && (i_waddr != '0);
  assign w_hit_testnum = w_valid && (i_waddr == 5'(TESTNUM_REG));
  assign w_hit_result  = w_valid && (i_waddr == 5'(RESULT_REG));
  assign w_hit_done    = w_valid && (i_waddr == 5'(DONE_REG));

  // State register; clear has priority over normal progression.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= H_RUN;
    end else if (clear) begin
      r_state <= H_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: the result shadow is sampled before this edge, so the
  // result write must land in an earlier cycle than the done write.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == H_RUN) && w_hit_done && (i_wdata == XLEN'(DONE_MAGIC))) begin
      w_state_nxt = (r_result == XLEN'(RESULT_PASS)) ? H_PASSED : H_FAILED;
    end
  end

  // Shadow registers, only updated while the hart is still running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_testnum <= '0;
      r_result  <= '0;
    end else if (clear) begin
      r_testnum <= '0;
      r_result  <= '0;
    end else if (r_state == H_RUN) begin
      if (w_hit_testnum) r_testnum <= i_wdata;
      if (w_hit_result)  r_result  <= i_wdata;
    end
  end

  assign o_state   = r_state;
  assign o_testnum = r_testnum;

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor: aggregates per-hart results, enforces a global
// cycle timeout and presents sticky registered status.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned NUM_HARTS      = 2,
  parameter int unsigned TESTNUM_REG    = 3,
  parameter int unsigned DONE_REG       = 26,
  parameter int unsigned RESULT_REG     = 27,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [NUM_HARTS-1:0]      wb_we,
  input  logic [NUM_HARTS*5-1:0]    wb_waddr,
  input  logic [NUM_HARTS*XLEN-1:0] wb_wdata,
  output logic                      done,
  output logic                      done_pulse,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [2:0]                fail_hart,
  output logic [XLEN-1:0]           fail_testnum,
  output logic [CNT_W-1:0]          cycle_count
);

  hart_state_t     w_hstate  [NUM_HARTS];
  logic [XLEN-1:0] w_htestnum[NUM_HARTS];

  agg_state_t      r_state;
  agg_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic            r_done_pulse;
  logic [2:0]      r_fail_hart;
  logic [XLEN-1:0] r_fail_testnum;

  logic            w_all_fin;
  logic            w_any_fail;
  logic [2:0]      w_fail_idx;
  logic [XLEN-1:0] w_fail_tn;
  logic            w_tmo_hit;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    test_monitor_hart #(
      .XLEN       (XLEN),
      .TESTNUM_REG(TESTNUM_REG),
      .DONE_REG   (DONE_REG),
      .RESULT_REG (RESULT_REG)
    ) u_hart (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .i_we     (wb_we[h]),
      .i_waddr  (wb_waddr[5*h +: 5]),
      .i_wdata  (wb_wdata[XLEN*h +: XLEN]),
      .o_state  (w_hstate[h]),
      .o_testnum(w_htestnum[h])
    );
  end

  // Completion summary and lowest-index failing hart.
  always_comb begin
    w_all_fin  = 1'b1;
    w_any_fail = 1'b0;
    w_fail_idx = '0;
    w_fail_tn  = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (!hart_finished(w_hstate[h])) w_all_fin = 1'b0;
      if ((w_hstate[h] == H_FAILED) && !w_any_fail) begin
        w_any_fail = 1'b1;
        w_fail_idx = 3'(h);
        w_fail_tn  = w_htestnum[h];
      end
    end
  end

  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Aggregate next state; completion is checked before timeout so a hart
  // finishing on the last cycle still yields PASS/FAIL.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_RUN) begin
      if (w_all_fin) begin
        w_state_nxt = w_any_fail ? S_FAIL : S_PASS;
      end else if (w_tmo_hit) begin
        w_state_nxt = S_TIMEOUT;
      end
    end
  end

  // Aggregate state, cycle counter, done pulse and failure capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_RUN;
      r_cnt          <= '0;
      r_done_pulse   <= 1'b0;
      r_fail_hart    <= '0;
      r_fail_testnum <= '0;
    end else if (clear) begin
      r_state        <= S_RUN;
      r_cnt          <= '0;
      r_done_pulse   <= 1'b0;
      r_fail_hart    <= '0;
      r_fail_testnum <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_done_pulse <= (r_state == S_RUN) && (w_state_nxt != S_RUN);
      if (r_state == S_RUN) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if (w_state_nxt == S_FAIL) begin
          r_fail_hart    <= w_fail_idx;
          r_fail_testnum <= w_fail_tn;
        end
      end
    end
  end

  assign done         = (r_state != S_RUN);
  assign done_pulse   = r_done_pulse;
  assign pass         = (r_state == S_PASS);
  assign fail         = (r_state == S_FAIL);
  assign timeout      = (r_state == S_TIMEOUT);
  assign fail_hart    = r_fail_hart;
  assign fail_testnum = r_fail_testnum;
  assign cycle_count  = r_cnt;

endmodule

// File: tb/tb_test_monitor.sv
// Scoreboard bench for test_monitor: stimulus pushes the expected final
// status, the monitor pops and compares on every done_pulse.
module tb_test_monitor;

  localparam int XLEN  = 64;
  localparam int NH    = 2;
  localparam int CNT_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clear = 1'b0;
  logic [NH-1:0]      wb_we = '0;
  logic [NH*5-1:0]    wb_waddr = '0;
  logic [NH*XLEN-1:0] wb_wdata = '0;
  logic               done, done_pulse, pass, fail, timeout;
  logic [2:0]         fail_hart;
  logic [XLEN-1:0]    fail_testnum;
  logic [CNT_W-1:0]   cycle_count;

  always #5 clk = ~clk;

  test_monitor #(
    .XLEN          (XLEN),
    .NUM_HARTS     (NH),
    .TESTNUM_REG   (3),
    .DONE_REG      (26),
    .RESULT_REG    (27),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .done        (done),
    .done_pulse  (done_pulse),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .fail_hart   (fail_hart),
    .fail_testnum(fail_testnum),
    .cycle_count (cycle_count)
  );

  typedef struct {
    logic        p;
    logic        f;
    logic        t;
    logic [2:0]  fh;
    logic [63:0] ftn;
    logic [31:0] cc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_wr(input int h, input int a, input logic [63:0] d);
    wb_we[h]                = 1'b1;
    wb_waddr[5*h +: 5]      = 5'(a);
    wb_wdata[XLEN*h +: XLEN] = d;
  endtask

  task automatic commit();
    step();
    wb_we = '0;
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input logic p, input logic f, input logic t,
                      input logic [2:0] fh, input logic [63:0] ftn, input logic [31:0] cc);
    exp_t e;
    e.p = p; e.f = f; e.t = t; e.fh = fh; e.ftn = ftn; e.cc = cc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!done && n < maxc) begin
      step();
      n++;
    end
    chk("done_within_bound", {63'd0, done}, 64'd1);
    step();
    step();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_done"},  {63'd0, done},       64'd0);
    chk({tag, "_pulse"}, {63'd0, done_pulse}, 64'd0);
    chk({tag, "_pass"},  {63'd0, pass},       64'd0);
    chk({tag, "_fail"},  {63'd0, fail},       64'd0);
    chk({tag, "_tmo"},   {63'd0, timeout},    64'd0);
    chk({tag, "_fhart"}, {61'd0, fail_hart},  64'd0);
    chk({tag, "_ftn"},   fail_testnum,        64'd0);
    chk({tag, "_cnt"},   {32'd0, cycle_count}, 64'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    cyc = 0;
    check_idle("clear");
  endtask

  // Monitor: compare final status whenever the DUT signals completion.
  logic pulse_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pulse_prev) chk("pulse_width", {63'd0, done_pulse}, 64'd0);
        if (done_pulse) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done_pulse: got 1 expected 0 (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("sb_done",    {63'd0, done},        64'd1);
            chk("sb_pass",    {63'd0, pass},        {63'd0, e.p});
            chk("sb_fail",    {63'd0, fail},        {63'd0, e.f});
            chk("sb_timeout", {63'd0, timeout},     {63'd0, e.t});
            chk("sb_fhart",   {61'd0, fail_hart},   {61'd0, e.fh});
            chk("sb_ftn",     fail_testnum,         e.ftn);
            chk("sb_cnt",     {32'd0, cycle_count}, {32'd0, e.cc});
          end
        end
        pulse_prev = done_pulse;
      end else begin
        pulse_prev = 1'b0;
      end
    end
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    check_idle("reset");
    rst = 1'b1;
    cyc = 0;

    // Pass case: both harts finish at edge 10, aggregate at edge 11.
    push(1, 0, 0, 3'd0, 64'd0, 32'd11);
    set_wr(0, 3, 64'd2);  set_wr(1, 3, 64'd2);  commit();
    set_wr(0, 27, 64'd1); set_wr(1, 27, 64'd1); commit();
    set_wr(0, 0, 64'h1);  set_wr(1, 0, 64'hdead); commit();
    idle_until(9);
    set_wr(0, 26, 64'd1); set_wr(1, 26, 64'd1); commit();
    chk("pass_latency_done", {63'd0, done}, 64'd0);
    chk("pass_cnt_at_hart_done", {32'd0, cycle_count}, 64'd10);
    wait_done(5);
    // Writes after PASSED change nothing.
    set_wr(0, 3, 64'd9); set_wr(1, 27, 64'd0); commit();
    step();
    chk("post_pass_pass", {63'd0, pass}, 64'd1);
    chk("post_pass_ftn",  fail_testnum, 64'd0);
    chk("post_pass_cnt",  {32'd0, cycle_count}, 64'd11);

    // Clear then a quick new pass.
    do_clear();
    push(1, 0, 0, 3'd0, 64'd0, 32'd3);
    set_wr(0, 27, 64'd1); set_wr(1, 27, 64'd1); commit();
    set_wr(0, 26, 64'd1); set_wr(1, 26, 64'd1); commit();
    wait_done(5);

    // Fail case on hart1; x26=5 is ignored.
    do_clear();
    push(0, 1, 0, 3'd1, 64'd7, 32'd5);
    set_wr(0, 3, 64'd4);  set_wr(1, 3, 64'd7);  commit();
    set_wr(0, 27, 64'd1); set_wr(1, 27, 64'd0); commit();
    set_wr(0, 26, 64'd1); set_wr(1, 26, 64'd5); commit();
    set_wr(1, 26, 64'd1); commit();
    chk("x26_5_ignored", {63'd0, done}, 64'd0);
    wait_done(5);

    // Both fail (hart0 wrote done before result): lowest index reported.
    do_clear();
    push(0, 1, 0, 3'd0, 64'd5, 32'd3);
    set_wr(0, 3, 64'd5);  set_wr(1, 3, 64'd6);  commit();
    set_wr(0, 26, 64'd1); set_wr(1, 26, 64'd1); commit();
    set_wr(0, 27, 64'd1); set_wr(1, 3, 64'd9);  commit();
    wait_done(5);

    // Timeout: hart0 never writes x26.
    do_clear();
    push(0, 0, 1, 3'd0, 64'd0, 32'd50);
    set_wr(0, 27, 64'd1); set_wr(1, 27, 64'd1); commit();
    set_wr(1, 26, 64'd1); commit();
    idle_until(49);
    chk("tmo_not_yet", {63'd0, done}, 64'd0);
    wait_done(5);

    // Boundary: last hart finishes on the timeout cycle -> PASS.
    do_clear();
    push(1, 0, 0, 3'd0, 64'd0, 32'd50);
    set_wr(0, 27, 64'd1); set_wr(1, 27, 64'd1); commit();
    set_wr(0, 26, 64'd1); commit();
    idle_until(48);
    set_wr(1, 26, 64'd1); commit();
    wait_done(5);
    chk("boundary_no_tmo", {63'd0, timeout}, 64'd0);

    // Async reset from a terminal state.
    #2 rst = 1'b0;
    #1 check_idle("async_rst_done");
    step();
    rst = 1'b1;
    cyc = 0;
    set_wr(0, 3, 64'd3); commit();
    idle_until(5);
    chk("midrun_cnt", {32'd0, cycle_count}, 64'd5);
    #2 rst = 1'b0;
    #1 check_idle("async_rst_mid");
    step();
    rst = 1'b1;
    step();
    step();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
